// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data and the stop bit.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       busy,
    output logic       tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          line_n, ready_n, done_n;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          par, par_n;
`endif

    assign bit_end = (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            serial_out <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shreg      <= shreg_n;
            serial_out <= line_n;
            tx_ready   <= ready_n;
            busy       <= ~ready_n;
            tx_done    <= done_n;
`ifdef UART_TX_PARITY_EN
            par        <= par_n;
`endif
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_n = state;
        cnt_n   = (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        line_n  = serial_out;
        ready_n = tx_ready;
        done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                idx_n = '0;
                if (tx_valid && tx_ready) begin
                    state_n = START;
                    shreg_n = tx_data;
                    line_n  = 1'b0;
                    ready_n = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    line_n  = shreg[0];
                    shreg_n = shreg >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        line_n  = par;
`else
                        state_n = STOP;
                        line_n  = 1'b1;
`endif
                    end else begin
                        line_n  = shreg[0];
                        shreg_n = shreg >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    line_n  = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    line_n  = 1'b1;
                    ready_n = 1'b1;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                line_n  = 1'b1;
                ready_n = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Serialising transmit side of the team's UART link. Accepts an 8-bit byte over a valid/ready handshake. Emits one frame per byte, LSB first, each bit held for CLKS_PER_BIT clocks:
- start bit (0)
- 8 data bits
- optional even parity bit
- stop bit (1)

Its line output feeds the receiver path (start-bit detect, 9-bit shift register, stop-bit check) and matches that path's framing.

Parameters:
CLKS_PER_BIT, 10, clocks per serial bit period; legal range 2..65535; counter width is $clog2(CLKS_PER_BIT).

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  asynchronous, active-high reset.
tx_data  input  8  byte to send; sampled only on the accept edge.
tx_valid  input  1  tx_data is valid; must hold until accepted.
tx_ready  output  1  block can accept a byte; high only in IDLE.
serial_out  output  1  UART line; idles high.
busy  output  1  frame in progress; exactly ~tx_ready.
tx_done  output  1  one-cycle pulse on the first cycle back in IDLE after a stop bit.

Behaviour:
- Reset (async, any time, including mid-frame):
  - state=IDLE, serial_out=1, tx_ready=1, busy=0, tx_done=0.
  - bit counter and shift register cleared; any partial frame is abandoned, with no glitch low.
- All outputs are registered.
- Accept: on a rising edge with tx_valid & tx_ready, tx_data is latched into a shift register and state moves to START.
  - From that edge: serial_out=0, tx_ready=0.
  - Later changes on tx_data or tx_valid have no effect until the next IDLE.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Each non-IDLE state lasts exactly CLKS_PER_BIT cycles, timed by a clock counter that counts 0..CLKS_PER_BIT-1 and wraps.
  - DATA has a 3-bit index, 0..7. serial_out=shreg[0] and the register shifts right at each bit boundary. After index 7 wraps, the FSM leaves DATA.
  - STOP: serial_out=1.
  - At the end of STOP: state=IDLE, tx_ready=1, tx_done=1 for exactly that one cycle.
- Frame length: 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity), measured from the accept edge to tx_ready re-asserting.
- Back-to-back: if tx_valid is high while tx_done=1, the next byte is accepted on that edge.
  - The line therefore stays high for exactly 1 idle cycle beyond the stop bit between frames.
- tx_valid low in IDLE: line holds 1 indefinitely, with no spurious tx_done.
- tx_valid asserted while busy: ignored, not queued, and no error raised. The upstream must wait for tx_ready.

Optional Feature:
Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - serial_out = XOR of the 8 latched data bits (even parity), computed at accept.
  - Frame is 11 bits.
- Undefined: no PARITY state and no parity logic; frame is 10 bits.

Test Plan:
1. Reset then idle: assert rst mid-cycle, release, hold tx_valid=0 for 200 cycles -> serial_out=1, tx_ready=1, tx_done=0 throughout.
2. Single byte, CLKS_PER_BIT=10, tx_data=0xA5 -> serial_out holds each value for 10 cycles in this order:
   - start: 0
   - data (LSB first): 1,0,1,0,0,1,0,1
   - stop: 1
   Then tx_done pulses once at cycle 100 after accept, with tx_ready=1 that same cycle.
3. Back-to-back: 0x00 then 0xFF, with tx_valid held high -> second start bit begins exactly 1 cycle after the first frame's 10-cycle stop; exactly two tx_done pulses.
4. Data stability: change tx_data from 0x3C to 0xC3 one cycle after accept -> line carries 0x3C; tx_valid pulses while busy are ignored.
5. Reset mid-frame: assert rst during data bit 4 -> serial_out=1 asynchronously, no tx_done. A new 0x5A sent after release is framed correctly from its start bit.
6. With UART_TX_PARITY_EN, tx_data=0xA5 (4 ones) -> parity bit 0; tx_data=0x07 -> parity bit 1. Frame is 110 cycles, tx_done at cycle 110.
